// File: rtl/mem_master_arbiter.sv
// mem_master_arbiter: round-robin sharing of one SDRAM controller port among memory masters
module mem_master_arbiter #(
  parameter int NUM_MASTERS = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RD_TIMEOUT  = 255,
  localparam int IW = $clog2(NUM_MASTERS)
) (
  input  logic                              clk_i,
  input  logic                              srst_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [DATA_WIDTH-1:0]             m_rdata_o,
  output logic                              m_err_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH+IW-1:0]          mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic                              mem_ready_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  input  logic                              mem_rvalid_i
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_idx, r_mask_idx, w_gnt_idx;
  logic r_mask_v, w_gnt_v, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [TW-1:0] r_cnt;
  logic [NUM_MASTERS-1:0] r_ack, r_rvalid;
  logic w_accept, w_rd_done, w_timeout;
  // Descending scan so the eligible master closest to r_ptr is the last (winning) assignment
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (m_req_i[r_ptr + IW'(k)] && !(r_mask_v && (r_ptr + IW'(k)) == r_mask_idx)) begin
        w_gnt_v = 1'b1;
        w_gnt_idx = r_ptr + IW'(k);
      end
  end
  assign w_accept  = (r_state == ISSUE) && mem_ready_i;
  assign w_rd_done = (r_state == WAIT_RD) && mem_rvalid_i;
  assign w_timeout = (r_state == WAIT_RD) && !mem_rvalid_i && (r_cnt == TW'(RD_TIMEOUT - 1));
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)  ? (w_gnt_v ? ISSUE : IDLE) :
             (r_state == ISSUE) ? (mem_ready_i ? (r_we ? IDLE : WAIT_RD) : ISSUE) :
             (r_state == WAIT_RD) ? ((w_rd_done || w_timeout) ? IDLE : WAIT_RD) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_mask_idx <= '0;
      r_mask_v <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt <= '0;
      r_ack <= '0;
      r_rvalid <= '0;
      r_err <= 1'b0;
    end else begin
      r_ack <= '0;
      r_rvalid <= '0;
      r_err <= 1'b0;
      r_mask_v <= 1'b0;
      if (r_state == IDLE && w_gnt_v) begin
        r_idx <= w_gnt_idx;
        r_we <= m_we_i[w_gnt_idx];
        r_addr <= m_addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= m_wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_accept) begin
        r_ack[r_idx] <= 1'b1;
        r_cnt <= '0;
        if (r_we) begin
          r_ptr <= r_idx + IW'(1);
          r_mask_v <= 1'b1;
          r_mask_idx <= r_idx;
        end
      end
      if (w_rd_done || w_timeout) begin
        r_rvalid[r_idx] <= 1'b1;
        r_err <= w_timeout;
        r_rdata <= w_rd_done ? mem_rdata_i : '0;
        r_mask_v <= 1'b1;
        r_mask_idx <= r_idx;
        if (w_rd_done) r_ptr <= r_idx + IW'(1);
      end else if (r_state == WAIT_RD) r_cnt <= r_cnt + TW'(1);
    end
  end
  assign m_ack_o     = r_ack;
  assign m_rvalid_o  = r_rvalid;
  assign m_rdata_o   = r_rdata;
  assign m_err_o     = r_err;
  assign mem_req_o   = (r_state == ISSUE);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = {r_idx, r_addr};
  assign mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_master_arbiter.sv
// tb_mem_master_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_mem_master_arbiter;
  localparam int N = 16, AW = 16, DW = 16, TO = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst, mem_ready, mem_rvalid, m_err, mem_req, mem_we;
  logic [N-1:0] m_req, m_we, m_ack, m_rv, drop;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata, mem_wdata, mem_rdata;
  logic [AW+3:0] mem_addr;
  int n_chk = 0, n_fail = 0;
  int md_ph, md_ptr, md_idx, md_we, md_addr, md_wdata, md_wait, md_mask_v, md_mask_idx;
  logic [N-1:0] ex_ack, ex_rv;
  logic [DW-1:0] ex_rdata;
  logic ex_err;
  int gr[8];
  int n_gr;
  int exp2[6] = '{0, 5, 15, 0, 5, 15};

  mem_master_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .clk_i(clk), .srst_i(srst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_ack_o(m_ack), .m_rvalid_o(m_rv), .m_rdata_o(m_rdata),
    .m_err_o(m_err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .mem_rvalid_i(mem_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Phases: 0 waiting for a grant, 1 command offered, 2 awaiting read data
  task automatic model_step();
    int nm, j;
    bit found;
    if (srst) begin
      md_ph = 0; md_ptr = 0; md_idx = 0; md_we = 0; md_addr = 0; md_wdata = 0;
      md_wait = 0; md_mask_v = 0; md_mask_idx = 0;
      ex_ack = '0; ex_rv = '0; ex_rdata = '0; ex_err = 1'b0;
      return;
    end
    ex_ack = '0; ex_rv = '0; ex_err = 1'b0; nm = 0; found = 0;
    if (md_ph == 0) begin
      for (int k = 0; k < N; k++) begin
        j = (md_ptr + k) % N;
        if (!found && m_req[j] && !(md_mask_v != 0 && j == md_mask_idx)) begin
          found = 1; md_idx = j; md_we = int'(m_we[j]);
          md_addr = int'(m_addr[j*AW +: AW]); md_wdata = int'(m_wdata[j*DW +: DW]);
          md_ph = 1;
        end
      end
    end else if (md_ph == 1) begin
      if (mem_ready) begin
        ex_ack[md_idx] = 1'b1;
        if (md_we != 0) begin md_ptr = (md_idx + 1) % N; md_ph = 0; nm = 1; end
        else begin md_ph = 2; md_wait = 0; end
      end
    end else begin
      md_wait++;
      if (mem_rvalid) begin
        ex_rv[md_idx] = 1'b1; ex_rdata = mem_rdata; md_ptr = (md_idx + 1) % N; md_ph = 0; nm = 1;
      end else if (md_wait == TO) begin
        ex_rv[md_idx] = 1'b1; ex_err = 1'b1; ex_rdata = '0; md_ph = 0; nm = 1;
      end
    end
    md_mask_v = nm;
    md_mask_idx = md_idx;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("ack", m_ack, ex_ack);
    chk("rvalid", m_rv, ex_rv);
    chk("err", m_err, ex_err);
    chk("rdata", m_rdata, ex_rdata);
    chk("mem_req", mem_req, md_ph == 1);
    chk("mem_addr", mem_addr, (md_idx << AW) + md_addr);
    chk("mem_we", mem_we, md_we);
    chk("mem_wdata", mem_wdata, md_wdata);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    cyc();
    srst = 1'b0;
  endtask

  task automatic set_m(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[i] = 1'b1;
    m_we[i] = we;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  // Masters keep req through the cycle that shows their ack, then drop it for one cycle
  task automatic auto_masters(input logic [N-1:0] en, input int p_req, input int p_wr);
    for (int i = 0; i < N; i++) begin
      if (drop[i]) begin m_req[i] = 1'b0; drop[i] = 1'b0; end
      else if (m_ack[i]) drop[i] = 1'b1;
      else if (!m_req[i] && en[i] && $urandom_range(99) < 32'(p_req))
        set_m(i, $urandom_range(99) < 32'(p_wr), AW'($urandom), DW'($urandom));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; drop = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    do_reset();
    chk("reset_req", mem_req, 0);
    // single write, no backpressure
    mem_ready = 1'b1;
    set_m(3, 1'b1, 16'h0012, 16'hBEEF);
    cyc();
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h30012);
    chk("t1_we", mem_we, 1);
    chk("t1_wdata", mem_wdata, 32'hBEEF);
    cyc();
    chk("t1_ack", m_ack, 32'h0008);
    chk("t1_req_done", mem_req, 0);
    cyc();
    chk("t1_guard", mem_req, 0);
    m_req[3] = 1'b0;
    cyc();
    chk("t1_idle", mem_req, 0);
    // round-robin among 0, 5, 15
    m_req = '0;
    do_reset();
    n_gr = 0;
    for (int c = 0; c < 80 && n_gr < 6; c++) begin
      auto_masters(16'h8021, 100, 100);
      cyc();
      for (int i = 0; i < N; i++) if (m_ack[i] && n_gr < 8) begin gr[n_gr] = i; n_gr++; end
    end
    chk("t2_count", n_gr, 6);
    for (int k = 0; k < 6; k++) chk("t2_order", gr[k], exp2[k]);
    // read with data after 7 cycles
    m_req = '0; drop = '0;
    do_reset();
    set_m(7, 1'b0, 16'h0100, 16'h0000);
    cyc();
    cyc();
    chk("t3_ack", m_ack, 32'h0080);
    cyc();
    m_req[7] = 1'b0;
    repeat (5) cyc();
    chk("t3_wait", m_rv, 0);
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    cyc();
    chk("t3_rvalid", m_rv, 32'h0080);
    chk("t3_rdata", m_rdata, 32'h1234);
    chk("t3_err", m_err, 0);
    mem_rvalid = 1'b0; mem_rdata = 16'h5555;
    cyc();
    chk("t3_hold", m_rdata, 32'h1234);
    // backpressure
    mem_ready = 1'b0;
    set_m(2, 1'b1, 16'hABCD, 16'h1357);
    cyc();
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("t4_req", mem_req, 1);
      chk("t4_addr", mem_addr, 32'h2ABCD);
      chk("t4_wdata", mem_wdata, 32'h1357);
      chk("t4_noack", m_ack, 0);
    end
    mem_ready = 1'b1;
    cyc();
    chk("t4_ack", m_ack, 32'h0004);
    cyc();
    m_req[2] = 1'b0;
    cyc();
    chk("t4_single", m_ack, 0);
    // read timeout
    mem_rdata = 16'hAAAA;
    set_m(9, 1'b0, 16'h0042, 16'h0000);
    cyc();
    cyc();
    chk("t5_ack", m_ack, 32'h0200);
    for (int w = 1; w <= 8; w++) begin
      cyc();
      if (w == 1) m_req[9] = 1'b0;
      if (w < 8) chk("t5_wait", m_rv, 0);
    end
    chk("t5_rvalid", m_rv, 32'h0200);
    chk("t5_err", m_err, 1);
    chk("t5_rdata", m_rdata, 0);
    set_m(1, 1'b1, 16'h0001, 16'h0002);
    cyc();
    chk("t5_idle_err", m_err, 0);
    chk("t5_regrant", mem_req, 1);
    cyc();
    cyc();
    m_req[1] = 1'b0;
    // reset during a read, then a stray read strobe
    set_m(4, 1'b0, 16'h0777, 16'h0000);
    cyc();
    cyc();
    cyc();
    m_req[4] = 1'b0;
    cyc();
    srst = 1'b1;
    cyc();
    srst = 1'b0;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_rdata", m_rdata, 0);
    mem_rvalid = 1'b1; mem_rdata = 16'h9999;
    cyc();
    chk("t6_stray_rv", m_rv, 0);
    chk("t6_stray_rdata", m_rdata, 0);
    mem_rvalid = 1'b0;
    set_m(0, 1'b1, 16'h0010, 16'h0020);
    set_m(8, 1'b1, 16'h0030, 16'h0040);
    cyc();
    chk("t6_first", mem_addr >> AW, 0);
    chk("t6_req", mem_req, 1);
    // randomized traffic
    drop = '0;
    for (int c = 0; c < 3000; c++) begin
      auto_masters('1, 30, 50);
      mem_ready = $urandom_range(99) < 70;
      mem_rvalid = $urandom_range(99) < 15;
      mem_rdata = DW'($urandom);
      srst = $urandom_range(199) == 0;
      cyc();
    end
    srst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_master_arbiter.md
Name: mem_master_arbiter

Overview:
- Shares the single external SDRAM controller port between the delay/chorus memory masters (up to 16).
- Round-robin arbitration; one transaction in flight at a time.
- Each master gets a private address window: its index is prepended as address MSBs.
- Sits between the application-core memory masters and the SDRAM controller; one instance per memory interface.

Parameters:
NUM_MASTERS, 16, number of requesters (power of two, 2..16)
ADDR_WIDTH, 16, per-master word address width (20 - clog2(NUM_MASTERS))
DATA_WIDTH, 16, memory word width
RD_TIMEOUT, 255, max cycles to wait for read data before forced completion
IW (derived), clog2(NUM_MASTERS), master index width

Ports:
clk_i  in  1  system clock
srst_i  in  1  synchronous active-high reset
m_req_i  in  NUM_MASTERS  per-master request, held until m_ack_o
m_we_i  in  NUM_MASTERS  1=write, 0=read
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed per-master addresses, master 0 in LSBs
m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  packed per-master write data
m_ack_o  out  NUM_MASTERS  one-cycle pulse: command accepted by memory
m_rvalid_o  out  NUM_MASTERS  one-cycle pulse: m_rdata_o valid for that master
m_rdata_o  out  DATA_WIDTH  shared read data
m_err_o  out  1  one-cycle pulse with m_rvalid_o when the read timed out
mem_req_o  out  1  command valid to SDRAM controller
mem_we_o  out  1  command direction
mem_addr_o  out  ADDR_WIDTH+IW  {master index, master address}
mem_wdata_o  out  DATA_WIDTH  write data
mem_ready_i  in  1  controller accepts command when mem_req_o & mem_ready_i
mem_rdata_i  in  DATA_WIDTH  read data
mem_rvalid_i  in  1  read data strobe

Behaviour:
- Reset (srst_i sampled high on a rising edge): state IDLE; rr_ptr=0; skip mask clear; all outputs 0. srst_i overrides all other inputs.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE arbitration:
  - Select the first master i with m_req_i[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_MASTERS, excluding a masked master.
  - Register idx, we, addr and wdata of the selected master; go to ISSUE.
  - No eligible request: stay in IDLE.
- ISSUE:
  - mem_req_o=1; command outputs stable until accepted.
  - On mem_ready_i=1: m_ack_o[idx] pulses on the next cycle.
  - Write: go IDLE and set rr_ptr=idx+1 (wraps).
  - Read: go WAIT_RD and clear the timeout counter.
- WAIT_RD:
  - mem_req_o=0.
  - On mem_rvalid_i: m_rdata_o<=mem_rdata_i, m_rvalid_o[idx] pulses next cycle, rr_ptr=idx+1, go IDLE.
  - Timeout: counter reaches RD_TIMEOUT without mem_rvalid_i -> m_rdata_o<=0, m_rvalid_o[idx] and m_err_o pulse, go IDLE.
- m_rdata_o holds its last value between reads.
- Latency:
  - Request seen in IDLE cycle t -> mem_req_o high at t+1.
  - Accept at t+1 -> m_ack_o at t+2.
  - Minimum write turnaround: 2 cycles.
  - Read: m_rvalid_o one cycle after mem_rvalid_i.
- Re-grant guard:
  - Masters drop m_req_i the cycle after seeing m_ack_o, so req is still high during the first IDLE cycle after completion.
  - For that single IDLE cycle the just-served master is masked out of arbitration.
- mem_rvalid_i outside WAIT_RD is ignored; no output change.
- mem_ready_i outside ISSUE is ignored.
- Reset mid-transaction: transaction abandoned, no ack/rvalid issued, mem_req_o low in the cycle after reset.
- Simultaneous mem_rvalid_i and timeout expiry in the same cycle: data wins, m_err_o stays 0.
- Address mapping: mem_addr_o = {idx[IW-1:0], addr[ADDR_WIDTH-1:0]}. No arithmetic and no overflow into other windows.

Test Plan:
1. Write, no backpressure: master 3 writes addr 0x0012, data 0xBEEF, mem_ready_i=1 -> mem_addr_o=0x30012, mem_we_o=1, mem_wdata_o=0xBEEF at t+1; m_ack_o=0x0008 pulse at t+2; exactly one command issued.
2. Round-robin fairness: masters 0, 5, 15 request writes simultaneously and re-request after each ack -> grant order 0, 5, 15, 0, 5, 15; no master granted twice consecutively while others wait.
3. Read: master 7 reads addr 0x0100, mem_rvalid_i asserted 7 cycles after accept with 0x1234 -> m_rvalid_o=0x0080 pulse, m_rdata_o=0x1234, m_err_o=0.
4. Backpressure: mem_ready_i low for 10 cycles during ISSUE -> mem_req_o, mem_addr_o, mem_wdata_o constant throughout; a single ack after ready rises.
5. Read timeout: RD_TIMEOUT=8, mem_rvalid_i never asserted -> after 8 WAIT_RD cycles, m_rvalid_o and m_err_o pulse, m_rdata_o=0, state returns IDLE.
6. Reset mid-read: srst_i pulsed in WAIT_RD, then a stray mem_rvalid_i -> no m_rvalid_o, all outputs 0, next request from master 0 served first (rr_ptr=0).
